// File: rtl/seq_add32_unit.sv
// Multi-cycle add/subtract unit: one 16-bit carry-lookahead adder is reused over
// WIDTH/16 slices, least significant slice first, with the carry registered between slices.

module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  cg;

  // Two-level lookahead: 4-bit groups produce G/P, group carries are fully expanded.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    cg[0] = c_in;
    cg[1] = gg[0] | (gp[0] & c_in);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & c_in);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = cg[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    sum   = p ^ c;
    c_out = cg[4];
  end

endmodule

module seq_add32_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / 16;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a, op_b;
  logic             cin;
  logic [IDX_W-1:0] idx;

  logic [15:0]      slice_a, slice_b, cla_sum;
  logic             cla_cout;
  logic [WIDTH-1:0] result_next;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  // Select the active slice and splice its sum into the running result.
  always_comb begin
    slice_a     = '0;
    slice_b     = '0;
    result_next = result;
    for (int s = 0; s < NSLICE; s++) begin
      if (idx == IDX_W'(s)) begin
        slice_a               = op_a[s*16 +: 16];
        slice_b               = op_b[s*16 +: 16];
        result_next[s*16 +: 16] = cla_sum;
      end
    end
  end

  CLA_16bit u_cla (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (cin),
    .sum   (cla_sum),
    .c_out (cla_cout)
  );

  // B is stored pre-inverted for subtraction, so flags see the effective operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_a     <= '0;
      op_b     <= '0;
      cin      <= 1'b0;
      idx      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            cin   <= sub;
            idx   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          result <= result_next;
          cin    <= cla_cout;
          idx    <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            carry    <= cla_cout;
            overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (cla_sum[15] != op_a[WIDTH-1]);
            zero     <= (result_next == '0);
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add32_unit.sv
// Bench for seq_add32_unit: directed corner cases plus random ops checked
// against a plain-arithmetic reference model.

module tb_seq_add32_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry, overflow, zero;

  int vectors     = 0;
  int miscompares = 0;

  seq_add32_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
    end
  endtask

  // Reference: unsigned sum/difference, carry as "no borrow" for sub, overflow
  // when the exact signed result does not fit in 32 bits.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic msub,
                                output logic [31:0] r, output logic c, output logic v, output logic z);
    longint sa, sb, sr;
    logic [32:0] wide;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (msub) begin
      r  = ma - mb;
      c  = (ma >= mb);
      sr = sa - sb;
    end else begin
      wide = {1'b0, ma} + {1'b0, mb};
      r    = wide[31:0];
      c    = wide[32];
      sr   = sa + sb;
    end
    v = (sr != longint'($signed(r)));
    z = (r == 32'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic tsub, input int hold);
    logic [31:0] er;
    logic ec, ev, ez;
    int cnt;
    model(ta, tb, tsub, er, ec, ev, ez);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; sub = tsub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    checkOutput("latency", cnt, 32'd3);
    checkOutput("result", result, er);
    checkOutput("flags", {29'd0, carry, overflow, zero}, {29'd0, ec, ev, ez});
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      tick();
      checkOutput("hold_result", result, er);
      checkOutput("hold_flags", {29'd0, carry, overflow, zero}, {29'd0, ec, ev, ez});
      checkOutput("hold_hs", {30'd0, out_valid, in_ready}, 32'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("release_hs", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_flags", {29'd0, carry, overflow, zero}, 32'd0);
    checkOutput("reset_hs", {30'd0, out_valid, in_ready}, 32'd1);

    applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, 0);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    applyStimulus(32'd5, 32'd7, 1'b1, 0);
    applyStimulus(32'd7, 32'd7, 1'b1, 0);
    applyStimulus(32'h80000000, 32'h00000001, 1'b1, 0);
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0, 5);

    // Abort while the second slice is pending.
    a = 32'h0000FFFF; b = 32'h00000001; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_hs", {30'd0, out_valid, in_ready}, 32'd1);
    checkOutput("abort_flags", {29'd0, carry, overflow, zero}, 32'd0);
    applyStimulus(32'd1, 32'd2, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: ra = 32'hFFFFFFFF;
        2: rb = 32'h80000000;
        3: ra[15:0] = 16'hFFFF;
        default: ;
      endcase
      applyStimulus(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
